// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants and enums for the L1 cache controller
//
// Purpose: address-split widths and the state/select encodings used by
//          cache_control and wmask_gen (and the cache datapath).
// Ports:   none (package).
package cache_pkg;

   localparam int S_OFFSET = 5;                        // 32-byte line
   localparam int S_INDEX  = 3;                        // 8 sets
   localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;  // derived, do not override

   typedef enum logic [1:0] {
      IDLE,
      COMPARE,
      WRITEBACK,
      FILL
   } cache_state_t;

   // Physical memory line address: CPU tag for fills, victim tag for writebacks.
   typedef enum logic {
      ADDR_CPU,
      ADDR_WB
   } pmem_addr_sel_t;

   // Data array write source: CPU word replicated across the line, or pmem line.
   typedef enum logic {
      DIN_CPU,
      DIN_PMEM
   } data_in_sel_t;

endpackage

// File: rtl/wmask_gen.sv
// rtl/wmask_gen.sv - CPU byte enables to 32-byte line write mask
//
// Purpose: places the 4 CPU byte enables on the addressed 32-bit word of a
//          256-bit line. Shared with the datapath byte-merge.
// Ports:   byte_enable [3:0]         CPU byte enables
//          offset      [S_OFFSET-1:0] line byte offset (bits [1:0] ignored)
//          wmask       [31:0]        per-byte line write mask
module wmask_gen
   import cache_pkg::*;
(
   input  logic [3:0]          byte_enable,
   input  logic [S_OFFSET-1:0] offset,
   output logic [31:0]         wmask
);

   // Word select only; the byte position within the word comes from byte_enable.
   logic unused_byte_offset;
   assign unused_byte_offset = ^offset[1:0];

   assign wmask = {28'b0, byte_enable} << {offset[S_OFFSET-1:2], 2'b00};

endmodule

// File: rtl/cache_control.sv
// rtl/cache_control.sv - sequencing FSM for the 2-way write-back L1 cache
//
// Purpose: decodes hit/miss, schedules dirty-victim writeback and line fill,
//          and drives the datapath array write enables and mux selects.
// Ports:   clk, rst_n (async, active-low)
//          CPU side : mem_read, mem_write, mem_byte_enable, mem_offset -> mem_resp
//          datapath : hit, victim_dirty, victim_valid, lru_out in;
//                     data_in_sel, data_wmask0/1, load_tag, set_valid,
//                     set_dirty, clr_dirty, lru_load, lru_in out
//          pmem side: pmem_resp in; pmem_read, pmem_write, pmem_addr_sel out
module cache_control
   import cache_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [3:0]          mem_byte_enable,
   input  logic [S_OFFSET-1:0] mem_offset,
   output logic                mem_resp,
   input  logic [1:0]          hit,
   input  logic                victim_dirty,
   input  logic                victim_valid,
   input  logic                lru_out,
   input  logic                pmem_resp,
   output logic                pmem_read,
   output logic                pmem_write,
   output logic                pmem_addr_sel,
   output logic                data_in_sel,
   output logic [31:0]         data_wmask0,
   output logic [31:0]         data_wmask1,
   output logic [1:0]          load_tag,
   output logic [1:0]          set_valid,
   output logic [1:0]          set_dirty,
   output logic [1:0]          clr_dirty,
   output logic                lru_load,
   output logic                lru_in
);

   cache_state_t   state;
   cache_state_t   state_next;
   pmem_addr_sel_t addr_sel;
   data_in_sel_t   din_sel;
   logic [31:0]    cpu_mask;
   logic           is_hit;
   logic           hit_way;

   wmask_gen u_wmask_gen (
      .byte_enable (mem_byte_enable),
      .offset      (mem_offset),
      .wmask       (cpu_mask)
   );

   assign is_hit  = |hit;
   // hit == 2'b11 cannot happen with distinct tags; resolve it to way 0.
   assign hit_way = ~hit[0];

   assign pmem_addr_sel = addr_sel;
   assign data_in_sel   = din_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      mem_resp    = 1'b0;
      pmem_read   = 1'b0;
      pmem_write  = 1'b0;
      addr_sel    = ADDR_CPU;
      din_sel     = DIN_CPU;
      data_wmask0 = '0;
      data_wmask1 = '0;
      load_tag    = '0;
      set_valid   = '0;
      set_dirty   = '0;
      clr_dirty   = '0;
      lru_load    = 1'b0;
      lru_in      = 1'b0;

      case (state)
         IDLE: begin
            // Arrays are read this cycle; tags are compared next cycle.
            if (mem_read || mem_write) begin
               state_next = COMPARE;
            end
         end

         COMPARE: begin
            if (is_hit) begin
               mem_resp   = 1'b1;
               lru_load   = 1'b1;
               lru_in     = ~hit_way;
               state_next = IDLE;
               // A write takes priority when both read and write are requested.
               if (mem_write) begin
                  din_sel = DIN_CPU;
                  if (hit_way) begin
                     data_wmask1 = cpu_mask;
                  end else begin
                     data_wmask0 = cpu_mask;
                  end
                  set_dirty[hit_way] = 1'b1;
               end
            end else if (victim_valid && victim_dirty) begin
               state_next = WRITEBACK;
            end else begin
               state_next = FILL;
            end
         end

         WRITEBACK: begin
            pmem_write = 1'b1;
            addr_sel   = ADDR_WB;
            if (pmem_resp) begin
               state_next = FILL;
            end
         end

         FILL: begin
            pmem_read = 1'b1;
            addr_sel  = ADDR_CPU;
            din_sel   = DIN_PMEM;
            if (pmem_resp) begin
               if (lru_out) begin
                  data_wmask1 = '1;
               end else begin
                  data_wmask0 = '1;
               end
               load_tag[lru_out]  = 1'b1;
               set_valid[lru_out] = 1'b1;
               clr_dirty[lru_out] = 1'b1;
               // Re-run the compare: it now hits and merges any write data.
               state_next = COMPARE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - scoreboard bench for cache_control
module tb_cache_control;

   logic        clk;
   logic        rst_n;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mem_byte_enable;
   logic [4:0]  mem_offset;
   logic        mem_resp;
   logic [1:0]  hit;
   logic        victim_dirty;
   logic        victim_valid;
   logic        lru_out;
   logic        pmem_resp;
   logic        pmem_read;
   logic        pmem_write;
   logic        pmem_addr_sel;
   logic        data_in_sel;
   logic [31:0] data_wmask0;
   logic [31:0] data_wmask1;
   logic [1:0]  load_tag;
   logic [1:0]  set_valid;
   logic [1:0]  set_dirty;
   logic [1:0]  clr_dirty;
   logic        lru_load;
   logic        lru_in;

   cache_control dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .mem_offset      (mem_offset),
      .mem_resp        (mem_resp),
      .hit             (hit),
      .victim_dirty    (victim_dirty),
      .victim_valid    (victim_valid),
      .lru_out         (lru_out),
      .pmem_resp       (pmem_resp),
      .pmem_read       (pmem_read),
      .pmem_write      (pmem_write),
      .pmem_addr_sel   (pmem_addr_sel),
      .data_in_sel     (data_in_sel),
      .data_wmask0     (data_wmask0),
      .data_wmask1     (data_wmask1),
      .load_tag        (load_tag),
      .set_valid       (set_valid),
      .set_dirty       (set_dirty),
      .clr_dirty       (clr_dirty),
      .lru_load        (lru_load),
      .lru_in          (lru_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          lat;
      bit          wr;
      logic [31:0] m0;
      logic [31:0] m1;
      logic [1:0]  sd;
      logic        li;
      int          wbc;
      int          flc;
   } exp_t;

   typedef struct {
      logic [31:0] m0;
      logic [31:0] m1;
      logic [1:0]  way;
   } fill_t;

   exp_t  txn_q[$];
   fill_t fill_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   bit    mon_en   = 1'b0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   function automatic logic [127:0] outs();
      return {49'b0, mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel,
              data_wmask0, data_wmask1, load_tag, set_valid, set_dirty, clr_dirty,
              lru_load, lru_in};
   endfunction

   // Byte b of the line is written when it lies in the addressed word and its lane is enabled.
   function automatic logic [31:0] byte_mask(input logic [3:0] be, input logic [4:0] off);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 32; b++) begin
         if ((b / 4) == int'(off[4:2]) && be[b % 4]) m[b] = 1'b1;
      end
      return m;
   endfunction

   // Monitor: follows each access and compares against the scoreboard when the DUT responds.
   initial begin : monitor
      int    cyc, wbc, flc;
      bit    busy, stray, bad;
      exp_t  e;
      fill_t f;
      busy = 0; cyc = 0; wbc = 0; flc = 0; stray = 0; bad = 0;
      forever begin
         @(negedge clk);
         if (!rst_n || !mon_en) begin
            busy = 0;
            continue;
         end
         if (!busy && (mem_read || mem_write)) begin
            busy = 1; cyc = 0; wbc = 0; flc = 0; stray = 0; bad = 0;
         end
         if (busy) begin
            cyc++;
            if (pmem_read && pmem_write) bad = 1;
            if (pmem_write) begin
               wbc++;
               if (pmem_addr_sel !== 1'b1) bad = 1;
            end
            if (pmem_read) begin
               flc++;
               if (pmem_addr_sel !== 1'b0 || data_in_sel !== 1'b1) bad = 1;
            end
            if (load_tag != 2'b00) begin
               if (fill_q.size() == 0) begin
                  chk("fill_unexpected", load_tag, 2'b00);
               end else begin
                  f = fill_q.pop_front();
                  chk("fill_wmask0", data_wmask0, f.m0);
                  chk("fill_wmask1", data_wmask1, f.m1);
                  chk("fill_load_tag", load_tag, f.way);
                  chk("fill_set_valid", set_valid, f.way);
                  chk("fill_clr_dirty", clr_dirty, f.way);
                  chk("fill_set_dirty", set_dirty, 2'b00);
               end
            end else if (!mem_resp && ((|data_wmask0) || (|data_wmask1) || set_valid != 0 ||
                                       set_dirty != 0 || clr_dirty != 0 || lru_load)) begin
               stray = 1;
            end
            if (mem_resp) begin
               busy = 0;
               if (txn_q.size() == 0) begin
                  chk("resp_unexpected", mem_resp, 1'b0);
               end else begin
                  e = txn_q.pop_front();
                  chk("latency", cyc, e.lat);
                  chk("resp_wmask0", data_wmask0, e.m0);
                  chk("resp_wmask1", data_wmask1, e.m1);
                  chk("resp_set_dirty", set_dirty, e.sd);
                  chk("resp_lru_load", lru_load, 1'b1);
                  chk("resp_lru_in", lru_in, e.li);
                  chk("wb_cycles", wbc, e.wbc);
                  chk("fill_cycles", flc, e.flc);
                  chk("resp_other_writes", {load_tag, set_valid, clr_dirty, pmem_read, pmem_write}, 0);
                  chk("stray_array_write", stray, 1'b0);
                  chk("pmem_protocol", bad, 1'b0);
                  if (e.wr) chk("resp_din_sel", data_in_sel, 1'b0);
               end
            end
         end
      end
   end

   task automatic clear_inputs();
      mem_read = 0; mem_write = 0; mem_byte_enable = 0; mem_offset = 0;
      hit = 0; victim_dirty = 0; victim_valid = 0; lru_out = 0; pmem_resp = 0;
   endtask

   // Driver plus memory/datapath model for one CPU access.
   task automatic run_txn(input bit wr, input bit both, input logic [1:0] h, input bit vv,
                          input bit vd, input bit lru, input logic [3:0] be, input logic [4:0] off,
                          input int dwb, input int dfill, input bit stray_cmp, input bit stray_idle);
      exp_t  e;
      fill_t f;
      bit    miss, wb, fin_way, installed, resp;
      int    kind, k, cnt, cyc;
      miss    = (h == 2'b00);
      wb      = miss && vv && vd;
      fin_way = miss ? lru : (h[0] ? 1'b0 : 1'b1);
      e.lat   = miss ? ((wb ? dwb : 0) + dfill + 3) : 2;
      e.wr    = wr;
      e.m0    = (wr && !fin_way) ? byte_mask(be, off) : 32'h0;
      e.m1    = (wr && fin_way)  ? byte_mask(be, off) : 32'h0;
      e.sd    = wr ? (2'b01 << fin_way) : 2'b00;
      e.li    = ~fin_way;
      e.wbc   = wb ? dwb : 0;
      e.flc   = miss ? dfill : 0;
      txn_q.push_back(e);
      if (miss) begin
         f.m0  = lru ? 32'h0 : 32'hFFFF_FFFF;
         f.m1  = lru ? 32'hFFFF_FFFF : 32'h0;
         f.way = 2'b01 << lru;
         fill_q.push_back(f);
      end

      @(posedge clk); #1;
      mem_write = wr; mem_read = !wr || both; mem_byte_enable = be; mem_offset = off;
      hit = h; victim_valid = vv; victim_dirty = vd; lru_out = lru;
      installed = 0; kind = 0; cnt = 0; cyc = 0; resp = 0;
      @(negedge clk);
      while (!resp && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         pmem_resp = 0;
         if (installed) hit = 2'b01 << lru;
         if (pmem_write || pmem_read) begin
            k = pmem_write ? 1 : 2;
            if (k != kind) begin
               kind = k;
               cnt  = 0;
            end
            cnt++;
            if (cnt == ((kind == 1) ? dwb : dfill)) begin
               pmem_resp = 1;
               if (kind == 2) installed = 1;
            end
         end else begin
            kind = 0;
            if (stray_cmp && cyc == 1) pmem_resp = 1;
         end
         @(negedge clk);
         resp = mem_resp;
      end
      chk("txn_completed", resp, 1'b1);

      @(posedge clk); #1;
      clear_inputs();
      pmem_resp = stray_idle;
      @(negedge clk);
      chk("idle_outputs", outs(), 0);
      @(posedge clk); #1;
      pmem_resp = 0;
      @(negedge clk);
      chk("idle_after_stray", outs(), 0);
   endtask

   initial begin : stimulus
      int  n;
      bit  reached;
      logic [1:0] h;
      int  r;
      clear_inputs();
      rst_n = 0;
      #12;
      chk("reset_outputs", outs(), 0);
      mem_read = 1;
      #1;
      chk("reset_outputs_req", outs(), 0);
      mem_read = 0;
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      chk("post_reset_idle", outs(), 0);
      mon_en = 1;

      // Directed: read hit way1, write hit way1, clean miss, dirty miss.
      run_txn(0, 0, 2'b10, 1, 0, 1, 4'hF,    5'h08, 1, 1, 0, 0);
      run_txn(1, 0, 2'b10, 1, 0, 0, 4'b0110, 5'h14, 1, 1, 0, 0);
      run_txn(0, 0, 2'b00, 0, 0, 1, 4'hF,    5'h00, 1, 5, 0, 0);
      run_txn(1, 0, 2'b00, 1, 1, 0, 4'b1001, 5'h1C, 3, 4, 0, 0);
      // Stray pmem_resp in COMPARE (hit and miss) and in IDLE.
      run_txn(0, 0, 2'b01, 1, 1, 1, 4'h3,    5'h04, 1, 1, 1, 1);
      run_txn(1, 1, 2'b00, 1, 0, 0, 4'hC,    5'h10, 1, 2, 1, 1);
      run_txn(1, 0, 2'b11, 1, 1, 1, 4'h5,    5'h0F, 1, 1, 0, 0);

      // Reset during FILL.
      mon_en = 0;
      @(posedge clk); #1;
      mem_read = 1; hit = 2'b00; victim_valid = 0; lru_out = 1;
      reached = 0;
      for (int i = 0; i < 10 && !reached; i++) begin
         @(negedge clk);
         reached = pmem_read;
      end
      chk("rst_fill_reached", pmem_read, 1'b1);
      @(posedge clk); #3;
      rst_n = 0;
      #1;
      chk("rst_drops_pmem_read", pmem_read, 1'b0);
      chk("rst_outputs", outs(), 0);
      mem_read = 0;
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      chk("rst_idle", outs(), 0);
      mon_en = 1;
      run_txn(0, 0, 2'b01, 0, 0, 0, 4'hF, 5'h00, 1, 1, 0, 0);

      // Randomized accesses.
      n = 60;
      for (int t = 0; t < n; t++) begin
         r = $urandom_range(0, 7);
         case (r)
            0, 1: h = 2'b01;
            2, 3: h = 2'b10;
            4:    h = 2'b11;
            default: h = 2'b00;
         endcase
         run_txn($urandom_range(0, 1), ($urandom_range(0, 3) == 0), h,
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                 $urandom_range(1, 6), $urandom_range(1, 6),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
      end

      repeat (3) @(posedge clk);
      chk("txn_q_drained", txn_q.size(), 0);
      chk("fill_q_drained", fill_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
